ysyx_25020037_lsu: RTL
======================

Name: ysyx_25020037_lsu

Overview:
- Load/store stage; accepts one instruction record per handshake from the execute stage, performs at most one memory transaction, and hands a result record to the write-back stage.
- Input handshake: `exu_valid` is a registered single-cycle pulse. The execute stage advances only while `lsu_ready` is high.
- Memory side: split request/response bus, one transaction outstanding.
- Non-memory instructions pass through without any bus activity.

Parameters:
- PASS_W, 64, width of the opaque passthrough field (write-back control and CSR data) carried unchanged to the write-back stage.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- exu_valid  input  1  input record valid (pulse)
- lsu_ready  output  1  stage can accept a record this cycle
- lu_is_load  input  1  record is a load
- lu_is_store  input  1  record is a store
- lu_size  input  2  access size: 00 byte, 01 half, 10 word
- lu_unsigned  input  1  zero-extend the load result
- lu_addr  input  32  ALU result: effective address, or final result for non-memory records
- lu_wdata  input  32  store data (rs2)
- lu_pass  input  PASS_W  passthrough field
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  request accepted
- mem_req_wen  output  1  1 = write
- mem_req_addr  output  32  {lu_addr[31:2], 2'b00}
- mem_req_wdata  output  32  lane-replicated store data
- mem_req_wstrb  output  4  byte strobes (0000 on reads)
- mem_rsp_valid  input  1  response valid (single cycle)
- mem_rsp_rdata  input  32  read data
- mem_rsp_err  input  1  bus error
- lsu_valid  output  1  output record valid
- wbu_ready  input  1  write-back stage accepts
- lu_result  output  32  write-back data
- lu_err  output  1  access fault or misaligned access
- lu_pass_out  output  PASS_W  registered copy of lu_pass

Behaviour:
- Reset values (rst sampled high at a rising edge):
  - State = IDLE.
  - `mem_req_valid`, `lsu_valid`, `lu_err` = 0.
  - `lu_result`, `lu_pass_out`, `mem_req_*` = 0.
  - `lsu_ready` = 1 after reset.
- `lsu_ready` = (state == IDLE); it is combinational from state only.
- Capture: on exu_valid && lsu_ready, register all inputs. A pulse while not ready is a protocol violation and is ignored.
- Alignment check: half requires addr[0] = 0; word requires addr[1:0] = 0.
- FSM:
  - IDLE, on capture:
    - Non-memory record → DONE, with lu_result = lu_addr.
    - Misaligned access → DONE, with lu_err = 1 and lu_result = lu_addr. No bus request is issued.
    - Otherwise → REQ, with mem_req_valid = 1 from the next cycle.
  - REQ: hold valid and all request fields stable until mem_req_ready. On the handshake, drop valid and go to WAIT.
  - WAIT: on mem_rsp_valid:
    - If mem_rsp_err: lu_err = 1, lu_result = lu_addr.
    - Else if load: lu_result = the extracted load data.
    - Else (store): lu_result = 0.
    - Then → DONE.
  - DONE: lsu_valid = 1, with lu_result, lu_err and lu_pass_out held stable. On wbu_ready → IDLE, and lsu_valid drops the next cycle.
- The responder asserts mem_rsp_valid no earlier than one cycle after the request handshake. mem_rsp_valid is ignored in IDLE, REQ and DONE.
- Store lane formatting, with off = addr[1:0]:
  - Byte: wdata = {4{b}}, wstrb = 0001 << off.
  - Half: wdata = {2{h}}, wstrb = 0011 << off.
  - Word: wdata = data, wstrb = 1111.
- Load extraction: shift rdata right by 8 × off, take the low 8 or 16 bits, then sign- or zero-extend per lu_unsigned. lu_unsigned is ignored for word loads.
- Minimum latency, capture edge to lsu_valid:
  - Non-memory: 1 cycle.
  - Memory: 3 cycles (REQ with same-cycle ready, response one cycle later).
- Throughput: one record in flight. A new capture is possible the cycle after the DONE handshake.
- Reset mid-operation:
  - Any state returns to IDLE and any pending request is abandoned.
  - A late response arriving after reset is ignored (IDLE).
  - Any write already handed to the bus is not retracted.

Test Plan:
- Non-memory record: lu_addr = 0x12345678, wbu_ready = 1 → lsu_valid one cycle after capture, lu_result = 0x12345678, lu_err = 0, no mem_req_valid.
- lb at address 0x80000003, rdata = 0x80FF0011 → request address 0x80000000, wstrb 0000, lu_result = 0xFFFFFF80. With lu_unsigned = 1 → lu_result = 0x00000080.
- sh at address 0x80000102, data 0xAAAABEEF → wdata = 0xBEEFBEEF, wstrb = 1100, lu_result = 0.
- Backpressure: mem_req_ready held low 5 cycles, then wbu_ready held low 3 cycles → request fields and output record stay stable throughout, and lsu_ready = 0 until the DONE handshake.
- Error paths:
  - lw at address 0x80000002 → no bus request, lu_err = 1, lu_result = 0x80000002.
  - Bus error response on a lw → lu_err = 1.
- rst asserted in WAIT, with the response arriving 2 cycles after rst deasserts → state IDLE, lsu_valid stays 0, lsu_ready = 1, response ignored.

Source files
------------

// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: one record at a time, with a single outstanding split-bus transaction.
// Non-memory and misaligned records reach DONE one edge after capture. Records with a bus access pass through REQ and WAIT first.
module ysyx_25020037_lsu #(
  parameter int PASS_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              lsu_ready,
  input  logic              lu_is_load,
  input  logic              lu_is_store,
  input  logic [1:0]        lu_size,
  input  logic              lu_unsigned,
  input  logic [31:0]       lu_addr,
  input  logic [31:0]       lu_wdata,
  input  logic [PASS_W-1:0] lu_pass,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [31:0]       mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              lsu_valid,
  input  logic              wbu_ready,
  output logic [31:0]       lu_result,
  output logic              lu_err,
  output logic [PASS_W-1:0] lu_pass_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        is_load_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;

  logic        capture;
  logic        is_mem;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign lsu_ready = (state == IDLE);
  assign capture   = exu_valid && lsu_ready;
  assign is_mem    = lu_is_load || lu_is_store;
  // Size 2'b11 is treated as a word access throughout.
  assign misaligned = ((lu_size == 2'b01) && lu_addr[0]) ||
                      (lu_size[1] && (lu_addr[1:0] != 2'b00));

  always_comb begin
    st_wdata = lu_wdata;
    st_wstrb = 4'b1111;
    case (lu_size)
      2'b00: begin
        st_wdata = {4{lu_wdata[7:0]}};
        st_wstrb = 4'b0001 << lu_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{lu_wdata[15:0]}};
        st_wstrb = 4'b0011 << lu_addr[1:0];
      end
      default: begin
        st_wdata = lu_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
    if (!lu_is_store) st_wstrb = 4'b0000;
  end

  assign ld_shift = mem_rsp_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (size_q)
      2'b00:   ld_data = unsigned_q ? {24'b0, ld_shift[7:0]}
                                    : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = unsigned_q ? {16'b0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      is_load_q     <= 1'b0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
      addr_q        <= 32'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= 32'b0;
      mem_req_wdata <= 32'b0;
      mem_req_wstrb <= 4'b0;
      lsu_valid     <= 1'b0;
      lu_result     <= 32'b0;
      lu_err        <= 1'b0;
      lu_pass_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            is_load_q   <= lu_is_load && !lu_is_store;
            size_q      <= lu_size;
            unsigned_q  <= lu_unsigned;
            addr_q      <= lu_addr;
            lu_pass_out <= lu_pass;
            lu_err      <= 1'b0;
            if (!is_mem || misaligned) begin
              lu_result <= lu_addr;
              lu_err    <= is_mem;
              lsu_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_wen   <= lu_is_store;
              mem_req_addr  <= {lu_addr[31:2], 2'b00};
              mem_req_wdata <= st_wdata;
              mem_req_wstrb <= st_wstrb;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
              lu_err    <= 1'b1;
              lu_result <= addr_q;
            end else if (is_load_q) begin
              lu_result <= ld_data;
            end else begin
              lu_result <= 32'b0;
            end
            lsu_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (wbu_ready) begin
            lsu_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
